// File: rtl/minmax_pkg.sv
// Shared constants and state encoding for the signed min/max tracker.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional feature macro used by the tracker: MINMAX_TIE_COUNT_EN.
package minmax_pkg;

    localparam int W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [W-1:0] SMAX = 4'sd7;
    localparam logic signed [W-1:0] SMIN = -4'sd8;

endpackage

// File: rtl/signed_cmp4.sv
// 4-bit two's-complement comparator built on a ripple-carry a + ~b + 1.
// Latency: combinational. Backpressure: none.
module signed_cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       x_gt_y,
    output logic       x_lt_y,
    output logic       x_eq_y
);

    logic [4:0] carry;
    logic [3:0] diff;
    logic       ovf;

    always_comb begin
        carry    = 5'b0;
        diff     = 4'b0;
        carry[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            diff[i]      = a[i] ^ ~b[i] ^ carry[i];
            carry[i + 1] = (a[i] & ~b[i]) | (a[i] & carry[i]) | (~b[i] & carry[i]);
        end
        // Raw sign is wrong when the subtraction overflows (e.g. 7 - (-8)).
        ovf    = carry[4] ^ carry[3];
        x_lt_y = diff[3] ^ ovf;
        x_eq_y = ~|diff;
        x_gt_y = ~x_lt_y & ~x_eq_y;
    end

endmodule

// File: rtl/signed_minmax_tracker.sv
// Tracks running signed max/min and first-occurrence indices over a FRAME_LEN sample frame.
// Latency: result valid the cycle after the last accepted sample. Backpressure: result held until out_ready;
// input stalls pause the frame. MINMAX_TIE_COUNT_EN adds a max_ties output.
module signed_minmax_tracker
    import minmax_pkg::*;
#(
    parameter int W         = 4,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     max_val,
    output logic [W-1:0]     min_val,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] min_idx,
`ifdef MINMAX_TIE_COUNT_EN
    output logic [CNT_W-1:0] max_ties,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [W-1:0]     max_val_q, max_val_d;
    logic [W-1:0]     min_val_q, min_val_d;
    logic [CNT_W-1:0] max_idx_q, max_idx_d;
    logic [CNT_W-1:0] min_idx_q, min_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MINMAX_TIE_COUNT_EN
    logic [CNT_W-1:0] ties_q, ties_d;
`endif

    logic accept;
    logic gt_max, lt_max, eq_max;
    logic gt_min, lt_min, eq_min;
    logic cmp_unused;

    signed_cmp4 u_cmp_max (
        .a      (in_data),
        .b      (max_val_q),
        .x_gt_y (gt_max),
        .x_lt_y (lt_max),
        .x_eq_y (eq_max)
    );

    signed_cmp4 u_cmp_min (
        .a      (in_data),
        .b      (min_val_q),
        .x_gt_y (gt_min),
        .x_lt_y (lt_min),
        .x_eq_y (eq_min)
    );

`ifdef MINMAX_TIE_COUNT_EN
    assign cmp_unused = lt_max | gt_min | eq_min;
`else
    assign cmp_unused = lt_max | eq_max | gt_min | eq_min;
`endif

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d   = state_q;
        max_val_d = max_val_q;
        min_val_d = min_val_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        cnt_d     = cnt_q;
`ifdef MINMAX_TIE_COUNT_EN
        ties_d    = ties_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) state_d = FIRST;
            end
            FIRST: begin
                if (accept) begin
                    max_val_d = in_data;
                    min_val_d = in_data;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    cnt_d     = CNT_W'(1);
`ifdef MINMAX_TIE_COUNT_EN
                    ties_d    = CNT_W'(1);
`endif
                    state_d   = (FRAME_LEN == 1) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    // Strict compares only: a tie keeps the earliest index.
                    if (gt_max) begin
                        max_val_d = in_data;
                        max_idx_d = cnt_q;
                    end
                    if (lt_min) begin
                        min_val_d = in_data;
                        min_idx_d = cnt_q;
                    end
`ifdef MINMAX_TIE_COUNT_EN
                    if (gt_max)      ties_d = CNT_W'(1);
                    else if (eq_max) ties_d = ties_q + CNT_W'(1);
`endif
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered from the next state.
        in_ready_d  = (state_d == FIRST) || (state_d == RUN);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            max_val_q   <= '0;
            min_val_q   <= '0;
            max_idx_q   <= '0;
            min_idx_q   <= '0;
            cnt_q       <= '0;
`ifdef MINMAX_TIE_COUNT_EN
            ties_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            max_val_q   <= max_val_d;
            min_val_q   <= min_val_d;
            max_idx_q   <= max_idx_d;
            min_idx_q   <= min_idx_d;
            cnt_q       <= cnt_d;
`ifdef MINMAX_TIE_COUNT_EN
            ties_q      <= ties_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign max_val   = max_val_q;
    assign min_val   = min_val_q;
    assign max_idx   = max_idx_q;
    assign min_idx   = min_idx_q;
`ifdef MINMAX_TIE_COUNT_EN
    assign max_ties  = ties_q;
`endif

endmodule
